// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite write arbiter.
// Contents:
//   - BRESP response codes
//   - 2-bit FSM state encoding
//   - per-byte strobe masking helper
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ADDR = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Returns the data byte when its strobe bit is set, otherwise zero.
  function automatic logic [7:0] mask_byte(input logic [7:0] data_byte, input logic strb_bit);
    return strb_bit ? data_byte : 8'h00;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter (purely combinational).
// Ports:
//   req        in  [1:0]  request vector
//   last_grant in         index of the requester served most recently
//   grant      out [1:0]  one-hot grant, zero when no request
//   grant_idx  out        index of the granted requester
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = 1'b0;
    if (req == 2'b11) begin
      // Contention: the requester not served last time wins.
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = 1'b1;
    end
    grant = '0;
    if (|req) begin
      grant = grant_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/axi_lite_write_arbiter.sv
// Two-requester AXI4-Lite write controller. A round-robin arbiter picks a
// requester, its address/strobe-masked data/strobe are captured, then the AW
// and W channels are driven until both handshake, and the B response is
// returned to the winner.
// Ports:
//   ACLK, ARESETn              clock; synchronous active-high reset
//   req_valid/req_addr/
//   req_data/req_strb          packed per-requester request (slot 0 = low bits)
//   req_ready                  1-cycle pulse when a request is captured
//   req_done                   1-cycle pulse when its write response arrives
//   req_resp                   latched BRESP per requester
//   AW*/W*/B*                  AXI4-Lite write master channels
module axi_lite_write_arbiter
  import axi_lite_pkg::*;
#(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [1:0]            req_valid,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_data,
  input  logic [2*STRB_W-1:0]   req_strb,
  output logic [1:0]            req_ready,
  output logic [1:0]            req_done,
  output logic [3:0]            req_resp,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DATA_W-1:0]     WDATA,
  output logic [STRB_W-1:0]     WSTRB,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP
);

  logic [1:0]        state;
  logic              aw_done;
  logic              w_done;
  logic              last_grant;
  logic              cur;
  logic [1:0]        grant;
  logic              grant_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [STRB_W-1:0] sel_strb;
  logic [DATA_W-1:0] masked_data;
  logic              aw_next;
  logic              w_next;

  rr_arbiter_2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    sel_addr = grant_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    sel_data = grant_idx ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
    sel_strb = grant_idx ? req_strb[2*STRB_W-1:STRB_W] : req_strb[STRB_W-1:0];
  end

  always_comb begin
    masked_data = '0;
    for (int unsigned k = 0; k < STRB_W; k++) begin
      masked_data[8*k +: 8] = mask_byte(sel_data[8*k +: 8], sel_strb[k]);
    end
  end

  always_comb begin
    AWVALID = (state == ST_ADDR) && !aw_done;
    WVALID  = (state == ST_ADDR) && !w_done;
    BREADY  = (state == ST_RESP);
    // Include this cycle's handshakes so simultaneous completion moves on at once.
    aw_next = aw_done || (AWVALID && AWREADY);
    w_next  = w_done  || (WVALID && WREADY);
  end

  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      state      <= ST_IDLE;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      last_grant <= 1'b1;
      cur        <= 1'b0;
      AWADDR     <= '0;
      WDATA      <= '0;
      WSTRB      <= '0;
      req_ready  <= '0;
      req_done   <= '0;
      req_resp   <= '0;
    end else begin
      req_ready <= '0;
      req_done  <= '0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            cur       <= grant_idx;
            AWADDR    <= sel_addr;
            WDATA     <= masked_data;
            WSTRB     <= sel_strb;
            req_ready <= grant;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (aw_next && w_next) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= ST_RESP;
          end else begin
            aw_done <= aw_next;
            w_done  <= w_next;
          end
        end
        ST_RESP: begin
          if (BVALID) begin
            if (cur) begin
              req_resp[3:2] <= BRESP;
            end else begin
              req_resp[1:0] <= BRESP;
            end
            req_done[cur] <= 1'b1;
            last_grant    <= cur;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
module tb_axi_lite_write_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [1:0]  req_valid;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [7:0]  req_strb;
  logic [1:0]  req_ready;
  logic [1:0]  req_done;
  logic [3:0]  req_resp;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;

  int total = 0;
  int bad   = 0;

  axi_lite_write_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .req_ready(req_ready), .req_done(req_done), .req_resp(req_resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset;
    ARESETn = 1'b1; req_valid = 2'b11; req_addr = '1; req_data = '1; req_strb = '1;
    AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1; BRESP = 2'b11;
    tick; tick;
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
    total++; if (req_done !== 2'b00) begin bad++; $display("FAIL rst_done got=%b exp=00", req_done); end
    total++; if (req_resp !== 4'b0000) begin bad++; $display("FAIL rst_resp got=%b exp=0000", req_resp); end
    total++; if ({AWVALID, WVALID, BREADY} !== 3'b000) begin bad++; $display("FAIL rst_valids got=%b exp=000", {AWVALID, WVALID, BREADY}); end
    total++; if ({AWADDR, WDATA, WSTRB} !== 68'h0) begin bad++; $display("FAIL rst_payload got=%h exp=0", {AWADDR, WDATA, WSTRB}); end
    req_valid = 2'b00; BVALID = 1'b0; BRESP = 2'b00;
    ARESETn = 1'b0;
    tick;
    total++; if ({AWVALID, WVALID, BREADY, req_ready} !== 5'b0) begin bad++; $display("FAIL idle_quiet got=%b exp=00000", {AWVALID, WVALID, BREADY, req_ready}); end
  endtask

  task automatic test_req0_single;
    req_valid = 2'b01; req_addr = {32'hFFFF_0000, 32'h0000_0010};
    req_data = {32'h0BAD_F00D, 32'hDEAD_BEEF}; req_strb = 8'b1010_1111;
    tick;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL t1_ready got=%b exp=01", req_ready); end
    total++; if ({AWVALID, WVALID} !== 2'b11) begin bad++; $display("FAIL t1_valids got=%b exp=11", {AWVALID, WVALID}); end
    total++; if (AWADDR !== 32'h10) begin bad++; $display("FAIL t1_awaddr got=%h exp=00000010", AWADDR); end
    total++; if (WDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL t1_wdata got=%h exp=deadbeef", WDATA); end
    total++; if (WSTRB !== 4'b1111) begin bad++; $display("FAIL t1_wstrb got=%b exp=1111", WSTRB); end
    req_valid = 2'b00;
    tick;
    total++; if ({AWVALID, WVALID, BREADY, req_ready} !== 5'b00100) begin bad++; $display("FAIL t1_resp_entry got=%b exp=00100", {AWVALID, WVALID, BREADY, req_ready}); end
    tick;
    total++; if ({BREADY, req_done} !== 3'b100) begin bad++; $display("FAIL t1_resp_wait got=%b exp=100", {BREADY, req_done}); end
    BVALID = 1'b1; BRESP = 2'b00;
    tick;
    BVALID = 1'b0;
    total++; if (req_done !== 2'b01) begin bad++; $display("FAIL t1_done got=%b exp=01", req_done); end
    total++; if (req_resp[1:0] !== 2'b00) begin bad++; $display("FAIL t1_resp got=%b exp=00", req_resp[1:0]); end
    total++; if (BREADY !== 1'b0) begin bad++; $display("FAIL t1_bready_off got=%b exp=0", BREADY); end
    tick;
    total++; if (req_done !== 2'b00) begin bad++; $display("FAIL t1_done_pulse got=%b exp=00", req_done); end
  endtask

  task automatic test_req1_strobe;
    req_valid = 2'b10; req_addr = {32'h0000_0020, 32'h0000_0999};
    req_data = {32'h1234_5678, 32'hFFFF_FFFF}; req_strb = 8'b0101_1111;
    tick;
    req_valid = 2'b00;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL t2_ready got=%b exp=10", req_ready); end
    total++; if (AWADDR !== 32'h20) begin bad++; $display("FAIL t2_awaddr got=%h exp=00000020", AWADDR); end
    total++; if (WDATA !== 32'h0034_0078) begin bad++; $display("FAIL t2_wdata got=%h exp=00340078", WDATA); end
    total++; if (WSTRB !== 4'b0101) begin bad++; $display("FAIL t2_wstrb got=%b exp=0101", WSTRB); end
    tick;
    BVALID = 1'b1; BRESP = 2'b01;
    tick;
    BVALID = 1'b0;
    total++; if (req_done !== 2'b10) begin bad++; $display("FAIL t2_done got=%b exp=10", req_done); end
    total++; if (req_resp !== 4'b0100) begin bad++; $display("FAIL t2_resp got=%b exp=0100", req_resp); end
    tick;
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_ready [12] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00,
                                   2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    logic [1:0] exp_done  [12] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10,
                                   2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    // last_grant is 1 after the previous test, so requester 0 leads.
    req_valid = 2'b11; req_addr = {32'h0000_0200, 32'h0000_0100};
    req_data = {32'hBBBB_BBBB, 32'hAAAA_AAAA}; req_strb = 8'hFF;
    BVALID = 1'b1; BRESP = 2'b00;
    for (int k = 0; k < 12; k++) begin
      tick;
      total++; if (req_ready !== exp_ready[k]) begin bad++; $display("FAIL t3_ready[%0d] got=%b exp=%b", k, req_ready, exp_ready[k]); end
      total++; if (req_done !== exp_done[k]) begin bad++; $display("FAIL t3_done[%0d] got=%b exp=%b", k, req_done, exp_done[k]); end
    end
    req_valid = 2'b00; BVALID = 1'b0;
    total++; if (req_resp !== 4'b0000) begin bad++; $display("FAIL t3_resp got=%b exp=0000", req_resp); end
    tick;
    total++; if ({AWVALID, req_ready} !== 3'b000) begin bad++; $display("FAIL t3_idle got=%b exp=000", {AWVALID, req_ready}); end
  endtask

  task automatic test_aw_stall;
    req_valid = 2'b01; req_addr = {32'h0, 32'h0000_0044};
    req_data = {32'h0, 32'hA5A5_A5A5}; req_strb = 8'h0F;
    AWREADY = 1'b0; WREADY = 1'b1;
    tick;
    req_valid = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      AWREADY = (i == 4);
      total++; if (AWVALID !== 1'b1) begin bad++; $display("FAIL t4_awvalid[%0d] got=%b exp=1", i, AWVALID); end
      total++; if (AWADDR !== 32'h44) begin bad++; $display("FAIL t4_awaddr[%0d] got=%h exp=00000044", i, AWADDR); end
      total++; if (WVALID !== (i == 1)) begin bad++; $display("FAIL t4_wvalid[%0d] got=%b exp=%b", i, WVALID, (i == 1)); end
      total++; if (BREADY !== 1'b0) begin bad++; $display("FAIL t4_bready[%0d] got=%b exp=0", i, BREADY); end
      tick;
    end
    total++; if ({AWVALID, WVALID, BREADY} !== 3'b001) begin bad++; $display("FAIL t4_resp got=%b exp=001", {AWVALID, WVALID, BREADY}); end
    BVALID = 1'b1; BRESP = 2'b00;
    tick;
    BVALID = 1'b0;
    total++; if (req_done !== 2'b01) begin bad++; $display("FAIL t4_done got=%b exp=01", req_done); end
    tick;
  endtask

  task automatic test_slverr_early_bvalid;
    req_valid = 2'b10; req_addr = {32'h0000_0080, 32'h0};
    req_data = {32'hCAFE_F00D, 32'h0}; req_strb = 8'b1100_0000;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b1; BRESP = 2'b10;
    tick;
    req_valid = 2'b00;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL t5_ready got=%b exp=10", req_ready); end
    total++; if (WDATA !== 32'hCAFE_0000) begin bad++; $display("FAIL t5_wdata got=%h exp=cafe0000", WDATA); end
    total++; if (BREADY !== 1'b0) begin bad++; $display("FAIL t5_bready_addr got=%b exp=0", BREADY); end
    tick;
    total++; if ({AWVALID, WVALID, BREADY, req_done} !== 5'b11000) begin bad++; $display("FAIL t5_bvalid_ignored got=%b exp=11000", {AWVALID, WVALID, BREADY, req_done}); end
    AWREADY = 1'b1; WREADY = 1'b1;
    tick;
    total++; if (BREADY !== 1'b1) begin bad++; $display("FAIL t5_bready_resp got=%b exp=1", BREADY); end
    tick;
    BVALID = 1'b0; BRESP = 2'b00;
    total++; if (req_done !== 2'b10) begin bad++; $display("FAIL t5_done got=%b exp=10", req_done); end
    total++; if (req_resp !== 4'b1000) begin bad++; $display("FAIL t5_resp got=%b exp=1000", req_resp); end
    tick;
  endtask

  task automatic test_reset_mid;
    req_valid = 2'b01; req_addr = {32'h0, 32'h0000_0100};
    req_data = {32'h0, 32'h1122_3344}; req_strb = 8'h0F;
    tick;
    req_valid = 2'b00;
    tick;
    total++; if (BREADY !== 1'b1) begin bad++; $display("FAIL t6_in_resp got=%b exp=1", BREADY); end
    ARESETn = 1'b1; BVALID = 1'b1; BRESP = 2'b11;
    tick;
    total++; if ({req_ready, req_done, req_resp, AWVALID, WVALID, BREADY} !== 11'b0) begin bad++; $display("FAIL t6_rst_ctrl got=%b exp=0", {req_ready, req_done, req_resp, AWVALID, WVALID, BREADY}); end
    total++; if ({AWADDR, WDATA, WSTRB} !== 68'h0) begin bad++; $display("FAIL t6_rst_payload got=%h exp=0", {AWADDR, WDATA, WSTRB}); end
    ARESETn = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    tick;
    total++; if ({req_done, BREADY} !== 3'b000) begin bad++; $display("FAIL t6_no_done got=%b exp=000", {req_done, BREADY}); end
    req_valid = 2'b01; req_addr = {32'h0, 32'h0000_0200};
    req_data = {32'h0, 32'h5566_7788}; req_strb = 8'h03;
    tick;
    req_valid = 2'b00;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL t6_ready got=%b exp=01", req_ready); end
    total++; if ({AWADDR, WDATA} !== {32'h200, 32'h0000_7788}) begin bad++; $display("FAIL t6_payload got=%h exp=0000020000007788", {AWADDR, WDATA}); end
    tick;
    BVALID = 1'b1; BRESP = 2'b01;
    tick;
    BVALID = 1'b0;
    total++; if (req_done !== 2'b01) begin bad++; $display("FAIL t6_done got=%b exp=01", req_done); end
    total++; if (req_resp !== 4'b0001) begin bad++; $display("FAIL t6_resp got=%b exp=0001", req_resp); end
    tick;
  endtask

  initial begin
    test_reset;
    test_req0_single;
    test_req1_strobe;
    test_round_robin;
    test_aw_stall;
    test_slverr_early_bvalid;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
